// File: rtl/l2_flush_sequencer.sv
// l2_flush_sequencer
// Maintenance sequencer for the coherent L2. Accepts flush-all or
// flush-by-address commands from the L2 config slave and walks the tag
// array one (set, way) at a time. For each enabled way it reads the tag and
// writes back the line if it is dirty. It then invalidates every line that
// hits. Lines that miss are left untouched.
//
// Optional build macro:
//   L2_FLUSH_PERF_EN - adds output wb_count[15:0]. It counts writeback
//                      handshakes since the last accepted command and
//                      saturates at 16'hFFFF.
//
// Parameters:
//   SETS_W   - log2 of the L2 set count
//   WAYS     - number of L2 ways (1..8)
//   OFFSET_W - log2 of the line size in bytes
//   TAG_W    - derived tag width (not overridable)

module l2_flush_sequencer #(
  parameter int SETS_W   = 7,
  parameter int WAYS     = 2,
  parameter int OFFSET_W = 5,
  localparam int TAG_W   = 32 - OFFSET_W - SETS_W,
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              l2_clock_i,
  input  logic              l2_reset_i,

  // Command interface from the L2 config slave
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_all,
  input  logic [31:0]       cmd_addr,
  input  logic [WAYS-1:0]   way_enable,
  output logic              busy,
  output logic              done,

  // Tag-array port (through the port arbiter)
  output logic              tag_req_valid,
  input  logic              tag_req_ready,
  output logic              tag_req_write,
  output logic [SETS_W-1:0] tag_req_set,
  output logic [WAY_W-1:0]  tag_req_way,
  input  logic              tag_rsp_valid,
  input  logic              tag_rsp_vbit,
  input  logic              tag_rsp_dirty,
  input  logic [TAG_W-1:0]  tag_rsp_tag,

  // Writeback queue
  output logic              wb_req_valid,
  input  logic              wb_req_ready,
  output logic [31:0]       wb_req_addr,
  output logic [WAY_W-1:0]  wb_req_way,
  input  logic              wb_done
`ifdef L2_FLUSH_PERF_EN
  ,
  output logic [15:0]       wb_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WB,
    S_WBWAIT,
    S_INV,
    S_NEXT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              all_q, all_d;
  logic [WAYS-1:0]   wayEn_q, wayEn_d;
  logic [SETS_W-1:0] set_q, set_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]  rspTag_q, rspTag_d;

  logic              cmdAccept;
  logic              lineHit;
  logic              lastSet;
  logic              nextFound;
  logic [WAY_W-1:0]  nextWay;

  // The line-offset bits of cmd_addr carry no meaning for a line flush.
  logic unusedAddrBits;
  assign unusedAddrBits = ^cmd_addr[OFFSET_W-1:0];

  // Lowest set bit of a way mask. A descending scan leaves the smallest
  // index in the result. An empty mask yields 0, which is never used
  // because an empty mask skips the walk.
  function automatic logic [WAY_W-1:0] lowestOf(input logic [WAYS-1:0] mask);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (mask[i]) idx = WAY_W'(i);
    end
    return idx;
  endfunction

  assign cmdAccept = cmd_valid && (state_q == S_IDLE);
  assign lineHit   = tag_rsp_vbit && (all_q || (tag_rsp_tag == tag_q));
  assign lastSet   = (set_q == {SETS_W{1'b1}});

  // Find the next enabled way strictly above the current one.
  always_comb begin
    nextFound = 1'b0;
    nextWay   = way_q;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (wayEn_q[i] && (i > int'(way_q))) begin
        nextFound = 1'b1;
        nextWay   = WAY_W'(i);
      end
    end
  end

  // Next-state logic for the walk and for the latched command context.
  always_comb begin
    state_d  = state_q;
    all_d    = all_q;
    wayEn_d  = wayEn_q;
    set_d    = set_q;
    way_d    = way_q;
    tag_d    = tag_q;
    rspTag_d = rspTag_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          all_d   = cmd_all;
          wayEn_d = way_enable;
          set_d   = cmd_all ? '0 : cmd_addr[OFFSET_W +: SETS_W];
          tag_d   = cmd_addr[31 -: TAG_W];
          way_d   = lowestOf(way_enable);
          state_d = (way_enable == '0) ? S_DONE : S_READ;
        end
      end

      S_READ: begin
        if (tag_req_ready) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (tag_rsp_valid) begin
          rspTag_d = tag_rsp_tag;
          if (!lineHit)          state_d = S_NEXT;
          else if (tag_rsp_dirty) state_d = S_WB;
          else                   state_d = S_INV;
        end
      end

      S_WB: begin
        if (wb_req_ready) state_d = S_WBWAIT;
      end

      S_WBWAIT: begin
        if (wb_done) state_d = S_INV;
      end

      S_INV: begin
        if (tag_req_ready) state_d = S_NEXT;
      end

      S_NEXT: begin
        if (nextFound) begin
          way_d   = nextWay;
          state_d = S_READ;
        end else if (all_q && !lastSet) begin
          set_d   = set_q + 1'b1;
          way_d   = lowestOf(wayEn_q);
          state_d = S_READ;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and context registers. Reset abandons any walk in progress.
  always_ff @(posedge l2_clock_i or posedge l2_reset_i) begin
    if (l2_reset_i) begin
      state_q  <= S_IDLE;
      all_q    <= 1'b0;
      wayEn_q  <= '0;
      set_q    <= '0;
      way_q    <= '0;
      tag_q    <= '0;
      rspTag_q <= '0;
    end else begin
      state_q  <= state_d;
      all_q    <= all_d;
      wayEn_q  <= wayEn_d;
      set_q    <= set_d;
      way_q    <= way_d;
      tag_q    <= tag_d;
      rspTag_q <= rspTag_d;
    end
  end

  // The request fields come only from registers. This keeps them stable
  // for as long as a request is stalled.
  always_comb begin
    cmd_ready     = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    tag_req_valid = (state_q == S_READ) || (state_q == S_INV);
    tag_req_write = (state_q == S_INV);
    tag_req_set   = set_q;
    tag_req_way   = way_q;
    wb_req_valid  = (state_q == S_WB);
    wb_req_addr   = {rspTag_q, set_q, {OFFSET_W{1'b0}}};
    wb_req_way    = way_q;
  end

`ifdef L2_FLUSH_PERF_EN
  logic [15:0] wbCount_q, wbCount_d;

  // Writeback counter: cleared on accept, saturating, held after done.
  always_comb begin
    wbCount_d = wbCount_q;
    if (cmdAccept) begin
      wbCount_d = '0;
    end else if (wb_req_valid && wb_req_ready && (wbCount_q != 16'hFFFF)) begin
      wbCount_d = wbCount_q + 16'd1;
    end
  end

  // Writeback counter register.
  always_ff @(posedge l2_clock_i or posedge l2_reset_i) begin
    if (l2_reset_i) wbCount_q <= '0;
    else            wbCount_q <= wbCount_d;
  end

  assign wb_count = wbCount_q;
`endif

endmodule

// File: tb/tb_l2_flush_sequencer.sv
// tb_l2_flush_sequencer
// Directed bench for l2_flush_sequencer, built with SETS_W=2, WAYS=2 and
// OFFSET_W=5, so TAG_W=25. A small tag-array model answers reads one cycle
// after the handshake. A writeback model pulses wb_done a programmable
// number of cycles after each writeback handshake. A monitor logs every
// handshake so the directed steps can check order, counts and timing.

module tb_l2_flush_sequencer;

  localparam int SETS_W   = 2;
  localparam int WAYS     = 2;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = 32 - OFFSET_W - SETS_W;
  localparam int WAY_W    = 1;
  localparam int LOGN     = 256;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_all;
  logic [31:0]       cmd_addr;
  logic [WAYS-1:0]   way_enable;
  logic              busy;
  logic              done;
  logic              tag_req_valid;
  logic              tag_req_ready;
  logic              tag_req_write;
  logic [SETS_W-1:0] tag_req_set;
  logic [WAY_W-1:0]  tag_req_way;
  logic              tag_rsp_valid = 1'b0;
  logic              tag_rsp_vbit  = 1'b0;
  logic              tag_rsp_dirty = 1'b0;
  logic [TAG_W-1:0]  tag_rsp_tag   = '0;
  logic              wb_req_valid;
  logic              wb_req_ready;
  logic [31:0]       wb_req_addr;
  logic [WAY_W-1:0]  wb_req_way;
  logic              wb_done = 1'b0;
`ifdef L2_FLUSH_PERF_EN
  logic [15:0]       wb_count;
`endif

  l2_flush_sequencer #(
    .SETS_W   (SETS_W),
    .WAYS     (WAYS),
    .OFFSET_W (OFFSET_W)
  ) dut (
    .l2_clock_i    (clk),
    .l2_reset_i    (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_all       (cmd_all),
    .cmd_addr      (cmd_addr),
    .way_enable    (way_enable),
    .busy          (busy),
    .done          (done),
    .tag_req_valid (tag_req_valid),
    .tag_req_ready (tag_req_ready),
    .tag_req_write (tag_req_write),
    .tag_req_set   (tag_req_set),
    .tag_req_way   (tag_req_way),
    .tag_rsp_valid (tag_rsp_valid),
    .tag_rsp_vbit  (tag_rsp_vbit),
    .tag_rsp_dirty (tag_rsp_dirty),
    .tag_rsp_tag   (tag_rsp_tag),
    .wb_req_valid  (wb_req_valid),
    .wb_req_ready  (wb_req_ready),
    .wb_req_addr   (wb_req_addr),
    .wb_req_way    (wb_req_way),
    .wb_done       (wb_done)
`ifdef L2_FLUSH_PERF_EN
    ,
    .wb_count      (wb_count)
`endif
  );

  int testCount = 0;
  int failCount = 0;

  // Tag-array contents, written only by the directed sequence
  logic             memV [4][2];
  logic             memD [4][2];
  logic [TAG_W-1:0] memT [4][2];
  int               wbDelay = 1;

  // Handshake logs, written only by the monitor
  int          cyc = 0;
  int          readCnt = 0;
  int          invCnt = 0;
  int          wbCnt = 0;
  int          doneCnt = 0;
  int          acceptCnt = 0;
  int          tagValidCycles = 0;
  int          readSetLog [LOGN];
  int          readWayLog [LOGN];
  int          invSetLog  [LOGN];
  int          invWayLog  [LOGN];
  int          invCycLog  [LOGN];
  logic [31:0] wbAddrLog  [LOGN];
  int          wbWayLog   [LOGN];
  int          wbCycLog   [LOGN];

  logic rdHs;
  int   rdSet;
  int   rdWay;
  int   wbLeft = 0;

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tag-array read responder with a one-cycle response
  always @(posedge clk) begin
    rdHs  = tag_req_valid && tag_req_ready && !tag_req_write && !rst;
    rdSet = int'(tag_req_set);
    rdWay = int'(tag_req_way);
    #1;
    tag_rsp_valid = rdHs;
    tag_rsp_vbit  = rdHs ? memV[rdSet][rdWay] : 1'b0;
    tag_rsp_dirty = rdHs ? memD[rdSet][rdWay] : 1'b0;
    tag_rsp_tag   = rdHs ? memT[rdSet][rdWay] : '0;
  end

  // Writeback engine: wb_done is seen wbDelay edges after the handshake
  always @(posedge clk) begin
    if (rst) begin
      wbLeft = 0;
    end else begin
      if (wbLeft > 0) wbLeft = wbLeft - 1;
      if (wb_req_valid && wb_req_ready) wbLeft = wbDelay;
    end
    #1;
    wb_done = (wbLeft == 1);
  end

  // Handshake monitor
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (tag_req_valid) tagValidCycles = tagValidCycles + 1;
      if (tag_req_valid && tag_req_ready) begin
        if (tag_req_write) begin
          if (invCnt < LOGN) begin
            invSetLog[invCnt] = int'(tag_req_set);
            invWayLog[invCnt] = int'(tag_req_way);
            invCycLog[invCnt] = cyc;
          end
          invCnt = invCnt + 1;
        end else begin
          if (readCnt < LOGN) begin
            readSetLog[readCnt] = int'(tag_req_set);
            readWayLog[readCnt] = int'(tag_req_way);
          end
          readCnt = readCnt + 1;
        end
      end
      if (wb_req_valid && wb_req_ready) begin
        if (wbCnt < LOGN) begin
          wbAddrLog[wbCnt] = wb_req_addr;
          wbWayLog[wbCnt]  = int'(wb_req_way);
          wbCycLog[wbCnt]  = cyc;
        end
        wbCnt = wbCnt + 1;
      end
      if (done) doneCnt = doneCnt + 1;
      if (cmd_valid && cmd_ready) acceptCnt = acceptCnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
    end
  endtask

  // Present one command at a negedge, then drop cmd_valid after the accept
  // edge unless the caller wants it held.
  task automatic applyStimulus(input logic all, input logic [31:0] addr,
                               input logic [WAYS-1:0] we, input bit keepValid);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_all    = all;
    cmd_addr   = addr;
    way_enable = we;
    @(negedge clk);
    if (!keepValid) cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, done, 1);
  endtask

  task automatic clearMem();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 2; w++) begin
        memV[s][w] = 1'b0;
        memD[s][w] = 1'b0;
        memT[s][w] = '0;
      end
    end
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_done"}, done, 0);
    checkOutput({pfx, "_cmdReady"}, cmd_ready, 1);
    checkOutput({pfx, "_tagReqValid"}, tag_req_valid, 0);
    checkOutput({pfx, "_wbReqValid"}, wb_req_valid, 0);
`ifdef L2_FLUSH_PERF_EN
    checkOutput({pfx, "_wbCount"}, wb_count, 0);
`endif
  endtask

  // Directed sequence
  initial begin
    int baseRead, baseInv, baseWb, baseDone, baseAcc, baseTv, way1Hits, n;
    logic [TAG_W-1:0] expTag;
    logic [SETS_W-1:0] expSet;
    logic [31:0] expAddr;

    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_all       = 1'b0;
    cmd_addr      = '0;
    way_enable    = '0;
    tag_req_ready = 1'b1;
    wb_req_ready  = 1'b1;
    clearMem();
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single-line clean hit in way 1 of set 1; way 0 holds another tag
    clearMem();
    memV[1][0] = 1'b1; memT[1][0] = 25'h0_0111;
    memV[1][1] = 1'b1; memT[1][1] = 25'h0_ABCD;
    baseRead = readCnt; baseInv = invCnt; baseWb = wbCnt; baseDone = doneCnt;
    applyStimulus(1'b0, {25'h0_ABCD, 2'd1, 5'h1F}, 2'b11, 1'b0);
    checkOutput("t1_busyAfterAccept", busy, 1);
    checkOutput("t1_cmdReadyBusy", cmd_ready, 0);
    waitDone("t1_done", 40);
    repeat (3) @(negedge clk);
    checkOutput("t1_readCount", readCnt - baseRead, 2);
    checkOutput("t1_read0Way", readWayLog[baseRead], 0);
    checkOutput("t1_read1Way", readWayLog[baseRead + 1], 1);
    checkOutput("t1_read1Set", readSetLog[baseRead + 1], 1);
    checkOutput("t1_invCount", invCnt - baseInv, 1);
    checkOutput("t1_invSet", invSetLog[baseInv], 1);
    checkOutput("t1_invWay", invWayLog[baseInv], 1);
    checkOutput("t1_wbCount", wbCnt - baseWb, 0);
    checkOutput("t1_donePulses", doneCnt - baseDone, 1);

    // Single-line dirty hit at 0x8000_1240: set 2, tag 0x1000024, way 0
    clearMem();
    memV[2][0] = 1'b1; memD[2][0] = 1'b1; memT[2][0] = 25'h100_0024;
    wbDelay = 5;
    baseRead = readCnt; baseInv = invCnt; baseWb = wbCnt; baseDone = doneCnt;
    applyStimulus(1'b0, 32'h8000_1240, 2'b11, 1'b0);
    waitDone("t2_done", 60);
    repeat (2) @(negedge clk);
    checkOutput("t2_wbCount", wbCnt - baseWb, 1);
    checkOutput("t2_wbAddr", wbAddrLog[baseWb], 64'h8000_1240);
    checkOutput("t2_wbWay", wbWayLog[baseWb], 0);
    checkOutput("t2_invCount", invCnt - baseInv, 1);
    checkOutput("t2_invSet", invSetLog[baseInv], 2);
    checkOutput("t2_invWay", invWayLog[baseInv], 0);
    checkOutput("t2_invAfterWbDone", invCycLog[baseInv] - wbCycLog[baseWb], 6);
    checkOutput("t2_readCount", readCnt - baseRead, 2);
    wbDelay = 1;

    // Flush-all on way 0 only, every line valid and dirty
    clearMem();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 2; w++) begin
        memV[s][w] = 1'b1;
        memD[s][w] = 1'b1;
        memT[s][w] = TAG_W'(32'h100 + 32'(s) + 32'(w) * 32'h40);
      end
    end
    baseRead = readCnt; baseInv = invCnt; baseWb = wbCnt; baseDone = doneCnt;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 2'b01, 1'b0);
    waitDone("t3_done", 200);
    repeat (2) @(negedge clk);
    checkOutput("t3_wbCount", wbCnt - baseWb, 4);
    checkOutput("t3_invCount", invCnt - baseInv, 4);
    checkOutput("t3_readCount", readCnt - baseRead, 4);
    for (int s = 0; s < 4; s++) begin
      expTag  = TAG_W'(32'h100 + 32'(s));
      expSet  = SETS_W'(s);
      expAddr = {expTag, expSet, 5'b0};
      checkOutput($sformatf("t3_wbAddr%0d", s), wbAddrLog[baseWb + s], expAddr);
      checkOutput($sformatf("t3_invSet%0d", s), invSetLog[baseInv + s], s);
      checkOutput($sformatf("t3_invWay%0d", s), invWayLog[baseInv + s], 0);
    end
    way1Hits = 0;
    for (int k = baseRead; k < readCnt; k++) if (readWayLog[k] == 1) way1Hits++;
    for (int k = baseInv; k < invCnt; k++) if (invWayLog[k] == 1) way1Hits++;
    checkOutput("t3_way1Untouched", way1Hits, 0);
    checkOutput("t3_donePulses", doneCnt - baseDone, 1);
`ifdef L2_FLUSH_PERF_EN
    checkOutput("t3_perfWbCount", wb_count, 4);
`endif

    // way_enable == 0: done the cycle after accept, no tag traffic
    baseTv = tagValidCycles; baseDone = doneCnt;
    applyStimulus(1'b0, 32'h0000_0040, 2'b00, 1'b0);
    checkOutput("t4_doneAfterAccept", done, 1);
    checkOutput("t4_busyInDone", busy, 1);
    checkOutput("t4_cmdReadyInDone", cmd_ready, 0);
    @(negedge clk);
    checkOutput("t4_doneDrops", done, 0);
    checkOutput("t4_idleAgain", busy, 0);
    checkOutput("t4_tagValidCycles", tagValidCycles - baseTv, 0);
    checkOutput("t4_donePulses", doneCnt - baseDone, 1);

    // Backpressure on both request ports, second command held during busy
    clearMem();
    memV[3][0] = 1'b1; memD[3][0] = 1'b1; memT[3][0] = 25'h0_BEEF;
    tag_req_ready = 1'b0;
    wb_req_ready  = 1'b0;
    baseAcc = acceptCnt; baseInv = invCnt;
    applyStimulus(1'b0, {25'h0_BEEF, 2'd3, 5'd0}, 2'b01, 1'b1);
    way_enable = 2'b00;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("t5_tagValid%0d", k), tag_req_valid, 1);
      checkOutput($sformatf("t5_tagWrite%0d", k), tag_req_write, 0);
      checkOutput($sformatf("t5_tagSet%0d", k), tag_req_set, 3);
      checkOutput($sformatf("t5_tagWay%0d", k), tag_req_way, 0);
      checkOutput($sformatf("t5_cmdReady%0d", k), cmd_ready, 0);
      @(negedge clk);
    end
    tag_req_ready = 1'b1;
    n = 0;
    while (!wb_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_wbReqSeen", wb_req_valid, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("t5_wbValid%0d", k), wb_req_valid, 1);
      checkOutput($sformatf("t5_wbAddr%0d", k), wb_req_addr, {25'h0_BEEF, 2'd3, 5'd0});
      checkOutput($sformatf("t5_wbWay%0d", k), wb_req_way, 0);
      checkOutput($sformatf("t5_wbCmdReady%0d", k), cmd_ready, 0);
      @(negedge clk);
    end
    wb_req_ready = 1'b1;
    waitDone("t5_done", 40);
    checkOutput("t5_secondNotYet", acceptCnt - baseAcc, 1);
    checkOutput("t5_invCount", invCnt - baseInv, 1);
    @(negedge clk);
    checkOutput("t5_readyAfterDone", cmd_ready, 1);
    @(negedge clk);
    checkOutput("t5_secondAccepted", acceptCnt - baseAcc, 2);
    checkOutput("t5_secondDone", done, 1);
    cmd_valid = 1'b0;
    @(negedge clk);

    // Reset asserted while waiting for wb_done
    clearMem();
    memV[0][0] = 1'b1; memD[0][0] = 1'b1; memT[0][0] = 25'h0_0777;
    wbDelay = 30;
    baseWb = wbCnt;
    applyStimulus(1'b0, {25'h0_0777, 2'd0, 5'd0}, 2'b01, 1'b0);
    n = 0;
    while ((wbCnt == baseWb) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_wbIssued", wbCnt - baseWb, 1);
    @(negedge clk);
    checkOutput("t6_inWbWait", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("t6_async");
    @(negedge clk);
    rst = 1'b0;
    wbDelay = 1;
    baseRead = readCnt; baseInv = invCnt; baseWb = wbCnt; baseDone = doneCnt;
    repeat (5) @(negedge clk);
    checkOutput("t6_quietReads", readCnt - baseRead, 0);
    checkOutput("t6_quietInvs", invCnt - baseInv, 0);
    checkOutput("t6_quietWbs", wbCnt - baseWb, 0);
    memD[0][0] = 1'b0;
    applyStimulus(1'b0, {25'h0_0777, 2'd0, 5'd0}, 2'b01, 1'b0);
    waitDone("t6_rerunDone", 40);
    repeat (2) @(negedge clk);
    checkOutput("t6_rerunInvCount", invCnt - baseInv, 1);
    checkOutput("t6_rerunInvSet", invSetLog[baseInv], 0);
    checkOutput("t6_rerunWbCount", wbCnt - baseWb, 0);
    checkOutput("t6_rerunDonePulses", doneCnt - baseDone, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/l2_flush_sequencer.md
Name: l2_flush_sequencer

Overview:
Maintenance sequencer for the coherent L2. Accepts flush commands issued by the L2 configuration slave, either flush-all or flush-by-address, gated by the configured way-enable mask. Walks the L2 tag array, writes back dirty lines through the writeback engine, then invalidates each affected line. Sits between the L2 config slave, the tag-array port arbiter and the writeback queue.

Parameters:
SETS_W, 7, log2 of L2 set count.
WAYS, 2, number of L2 ways (1..8).
OFFSET_W, 5, log2 of line size in bytes.
TAG_W, 32-OFFSET_W-SETS_W (20 by default), tag width; derived, do not override.

Ports:
l2_clock_i  in  1  clock
l2_reset_i  in  1  asynchronous, active-high reset
cmd_valid  in  1  flush command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_all  in  1  1 = flush all sets, 0 = flush the line at cmd_addr
cmd_addr  in  32  physical address for a single-line flush (offset bits ignored)
way_enable  in  WAYS  ways eligible for the flush; sampled on command accept
busy  out  1  high from the accept cycle until done
done  out  1  one-cycle pulse at completion
tag_req_valid  out  1  tag-array request
tag_req_ready  in  1  tag-array grant
tag_req_write  out  1  0 = read, 1 = invalidate (clear valid and dirty)
tag_req_set  out  SETS_W  set index
tag_req_way  out  $clog2(WAYS) (min 1)  way index
tag_rsp_valid  in  1  read response, one or more cycles after the read handshake
tag_rsp_vbit  in  1  line valid
tag_rsp_dirty  in  1  line dirty
tag_rsp_tag  in  TAG_W  stored tag
wb_req_valid  out  1  writeback request
wb_req_ready  in  1  writeback accepted
wb_req_addr  out  32  line address {tag,set,OFFSET_W'0}
wb_req_way  out  $clog2(WAYS)  way holding the data
wb_done  in  1  pulse: writeback data read out; line may be invalidated

Behaviour:
- Reset: state IDLE; busy=0, done=0, cmd_ready=1, tag_req_valid=0, wb_req_valid=0; counters cleared. Reset mid-operation abandons the walk with no further requests. The requester must also reset.
- cmd_ready = (state==IDLE). On accept, latch cmd_all, way_enable, set = cmd_all ? 0 : cmd_addr[OFFSET_W+:SETS_W], and the tag from cmd_addr[31:OFFSET_W+SETS_W]. The way counter starts at the lowest enabled way.
- way_enable==0 on accept: go to DONE; done pulses the cycle after accept. No tag traffic.
- States:
  - IDLE: wait for accept, then go to READ.
  - READ: tag_req_valid=1, write=0. On ready, go to WAIT.
  - WAIT: on tag_rsp_valid, the line hits if vbit & (cmd_all | tag==latched tag).
    - Hit and dirty: go to WB.
    - Hit and clean: go to INV.
    - Miss: go to NEXT.
  - WB: wb_req_valid=1, address built from the response tag. On ready, go to WBWAIT.
  - WBWAIT: on wb_done, go to INV.
  - INV: tag_req_valid=1, write=1. On ready, go to NEXT.
  - NEXT: advance to the next enabled way above the current one. If none remain:
    - cmd_all and set != all-ones: set+1, way = lowest enabled, go to READ.
    - Otherwise: go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Request outputs hold stable while valid&!ready. The valid signal never drops before its handshake.
- busy=1 in every state except IDLE, including DONE.
- tag_rsp_valid outside WAIT is ignored. wb_done outside WBWAIT is ignored.
- Set counter is SETS_W bits. The last set is detected before increment, so there is no wrap.
- Minimum per-line latency with ready always high and a 1-cycle response: miss 3 cycles; clean hit 4 cycles; dirty hit 4 cycles + writeback handshake + wb_done latency.

Optional Feature:
L2_FLUSH_PERF_EN:
- Defined: adds output wb_count[15:0], counting wb_req handshakes since the last accept. Cleared on accept, saturates at 16'hFFFF, holds after done. Reset value 0.
- Undefined: port and counter absent.

Test Plan:
- Single-line flush, WAYS=2, way_enable=2'b11, tag match in way1, line clean:
  - Reads of way0 (miss) then way1.
  - One invalidate of set S, way 1.
  - No wb_req; done pulses once.
- Single-line flush, dirty hit in way0, address 0x8000_1240:
  - wb_req_addr=0x8000_1240, way 0.
  - Invalidate is issued only after wb_done, which is delayed 5 cycles.
- Flush-all, SETS_W=2, way_enable=2'b01, all lines valid and dirty:
  - Exactly 4 writebacks and 4 invalidates on sets 0..3, way 0.
  - Way 1 is never touched; done after set 3.
- way_enable=0 with cmd_valid:
  - done pulses in the cycle after accept.
  - Zero tag_req_valid cycles.
- Backpressure: tag_req_ready and wb_req_ready low for 3 cycles each; second cmd_valid during busy:
  - Request outputs stay stable while stalled.
  - cmd_ready stays 0 and the second command is accepted only after done.
- Assert l2_reset_i in WBWAIT:
  - All outputs return to reset values asynchronously.
  - A new command then runs normally (with L2_FLUSH_PERF_EN, wb_count reads 0 after reset).
